// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between an instruction fetch port
// and a data load/store port. Data requests take priority over fetches.
// Each access runs until a latency counter finishes. The counter freezes
// while ram_busy is high. After every completion the block spends one idle
// "bubble" cycle, so a requester that still holds its request is not
// accepted twice.
//
// Handshake: i_fetch / d_read / d_write are level requests. The requester
// holds a request (and its address/data) until the matching ready pulses.
// i_ready / d_ready are one-cycle pulses. The requester must drop the request
// on the cycle it sees ready. The arbiter latches address, data and operation
// on accept, so later input changes do not affect the access in flight.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fetch,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] instruction_out,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  input  logic        ram_busy,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IFETCH  = 2'd1,
    S_DACCESS = 2'd2
  } state_t;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       bubble_q;

  // State is exported so external checkers can follow the FSM.
  assign dbg_state_o = state_q;

  // Arbitration FSM with registered RAM strobes, ready pulses and captured data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= 4'd0;
      bubble_q        <= 1'b0;
      i_ready         <= 1'b0;
      d_ready         <= 1'b0;
      ram_re          <= 1'b0;
      ram_we          <= 1'b0;
      ram_addr        <= 32'd0;
      ram_wdata       <= 32'd0;
      d_rdata         <= 32'd0;
      err             <= 1'b0;
      instruction_out <= NOP;
    end else begin
      // Ready pulses and the bubble flag last a single cycle.
      i_ready  <= 1'b0;
      d_ready  <= 1'b0;
      bubble_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The cycle right after a completion ignores all requests.
          if (!bubble_q) begin
            if (d_read || d_write) begin
              state_q   <= S_DACCESS;
              cnt_q     <= 4'd0;
              ram_addr  <= {d_addr[31:2], 2'b00};
              ram_wdata <= d_wdata;
              // A simultaneous read+write is treated as a write and flagged.
              ram_we    <= d_write;
              ram_re    <= ~d_write;
              if ((d_addr[1:0] != 2'b00) || (d_read && d_write)) begin
                err <= 1'b1;
              end
            end else if (i_fetch) begin
              state_q   <= S_IFETCH;
              cnt_q     <= 4'd0;
              ram_addr  <= {i_addr[31:2], 2'b00};
              ram_wdata <= 32'd0;
              ram_re    <= 1'b1;
              ram_we    <= 1'b0;
              if (i_addr[1:0] != 2'b00) begin
                err <= 1'b1;
              end
            end
          end
        end
        S_IFETCH, S_DACCESS: begin
          // A stall freezes the counter. Completion needs a non-stalled final cycle.
          if (!ram_busy) begin
            if (cnt_q == LAST_CNT) begin
              state_q  <= S_IDLE;
              cnt_q    <= 4'd0;
              bubble_q <= 1'b1;
              ram_re   <= 1'b0;
              ram_we   <= 1'b0;
              if (state_q == S_IFETCH) begin
                instruction_out <= ram_rdata;
                i_ready         <= 1'b1;
              end else begin
                d_ready <= 1'b1;
                if (!ram_we) begin
                  d_rdata <= ram_rdata;
                end
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. It has a TB-side RAM, a transaction-level reference
// memory and error model, table vectors, hand-written corner sequences and a
// randomized phase.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fetch, d_read, d_write, ram_busy;
  logic [31:0] i_addr, d_addr, d_wdata, ram_rdata;
  logic        i_ready, d_ready, ram_re, ram_we, err;
  logic [31:0] instruction_out, d_rdata, ram_addr, ram_wdata;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_fetch(i_fetch), .i_addr(i_addr), .i_ready(i_ready),
    .instruction_out(instruction_out),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_re(ram_re), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy), .err(err),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memories ----------------
  logic [31:0] tb_ram  [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return tb_ram.exists(a) ? tb_ram[a] : default_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] al;
    al = {a[31:2], 2'b00};
    return ref_mem.exists(al) ? ref_mem[al] : default_word(al);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    tb_ram[a]  = v;
    ref_mem[a] = v;
  endtask

  // RAM read data is presented half a cycle ahead of the sampling edge.
  always @(negedge clk) ram_rdata <= ram_re ? ram_read(ram_addr) : 32'd0;

  // The RAM stores whatever is on the write bus while the write strobe is high.
  always @(posedge clk) if (ram_we) tb_ram[ram_addr] = ram_wdata;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // The two ready pulses must never coincide.
  always @(negedge clk) begin
    if (!rst) check("ready_exclusive", {31'd0, i_ready & d_ready}, 32'd0);
  end

  // ---------------- reference model state ----------------
  logic        model_err;
  logic [31:0] model_drdata, model_instr;

  // ---------------- driver ----------------
  // kind: 0 fetch, 1 read, 2 write, 3 read+write (behaves as a write).
  task automatic do_access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                           input int stalls, input logic [31:0] exp_data, input logic exp_err);
    int k;
    bit is_wr;
    bit is_fetch;
    logic [31:0] al;
    is_fetch = (kind == 0);
    is_wr    = (kind >= 2);
    al       = {addr[31:2], 2'b00};
    @(negedge clk);
    if (is_fetch) begin
      i_fetch = 1'b1; i_addr = addr;
    end else begin
      d_read = (kind == 1 || kind == 3); d_write = is_wr; d_addr = addr; d_wdata = wdata;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(ram_re || ram_we) && k < 20);
    check("accept", {31'd0, ram_re | ram_we}, 32'd1);
    if (ram_re || ram_we) begin
      k = 0;
      while (1) begin
        check("ram_re", {31'd0, ram_re}, {31'd0, ~is_wr});
        check("ram_we", {31'd0, ram_we}, {31'd0, is_wr});
        check("ram_addr", ram_addr, al);
        if (is_wr) check("ram_wdata", ram_wdata, wdata);
        ram_busy = (k < stalls);
        @(negedge clk);
        k++;
        if (i_ready || d_ready || k >= 40) break;
      end
      ram_busy = 1'b0;
      check("latency", k, LAT + stalls);
      check("i_ready", {31'd0, i_ready}, {31'd0, is_fetch});
      check("d_ready", {31'd0, d_ready}, {31'd0, ~is_fetch});
      check("strobes_off", {30'd0, ram_re, ram_we}, 32'd0);
      if (is_fetch) check("instruction_out", instruction_out, exp_data);
      else          check("d_rdata", d_rdata, exp_data);
      check("err", {31'd0, err}, {31'd0, exp_err});
    end
    i_fetch = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  // Waits for the given ready to rise (ready_sel: 0 i_ready, 1 d_ready).
  task automatic wait_ready(input int ready_sel, output bit seen);
    int k;
    seen = 1'b0;
    for (k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = (ready_sel == 0) ? i_ready : d_ready;
    end
    check("ready_timeout", {31'd0, seen}, 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit seen;
    vecs[0] = '{0, 32'h0000_0004, 32'h0,           0, 32'h3E80_0093, 1'b0};
    vecs[1] = '{2, 32'h0000_0200, 32'hDEAD_BEEF,   3, 32'h0000_0000, 1'b0};
    vecs[2] = '{1, 32'h0000_0200, 32'h0,           0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1, 32'h0000_0102, 32'h0,           0, 32'h1111_2222, 1'b1};
    vecs[4] = '{0, 32'h0000_0008, 32'h0,           1, 32'h0050_0113, 1'b1};
    vecs[5] = '{3, 32'h0000_0300, 32'hCAFE_F00D,   0, 32'h1111_2222, 1'b1};
    vecs[6] = '{1, 32'h0000_0300, 32'h0,           2, 32'hCAFE_F00D, 1'b1};

    preload(32'h0000_0004, 32'h3E80_0093);
    preload(32'h0000_0008, 32'h0050_0113);
    preload(32'h0000_0100, 32'h1111_2222);
    preload(32'h0000_0020, 32'h0000_0073);

    i_fetch = 0; d_read = 0; d_write = 0; ram_busy = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_state", {30'd0, dbg_state_o}, 32'd0);
    check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
    check("rst_strobes", {30'd0, ram_re, ram_we}, 32'd0);
    check("rst_ram_addr", ram_addr, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_instr", instruction_out, NOP);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].stalls,
                vecs[i].exp_data, vecs[i].exp_err);
      if (vecs[i].kind >= 2) ref_mem[{vecs[i].addr[31:2], 2'b00}] = vecs[i].wdata;
    end
    model_err    = 1'b1;
    model_drdata = 32'hCAFE_F00D;
    model_instr  = 32'h0050_0113;

    // Simultaneous fetch and load: data first, bubble, then the fetch.
    @(negedge clk);
    i_fetch = 1'b1; i_addr = 32'h0000_0020;
    d_read  = 1'b1; d_addr = 32'h0000_0100;
    @(negedge clk);
    check("prio_ram_re", {31'd0, ram_re}, 32'd1);
    check("prio_ram_addr", ram_addr, 32'h0000_0100);
    wait_ready(1, seen);
    check("prio_d_rdata", d_rdata, 32'h1111_2222);
    check("prio_i_ready_low", {31'd0, i_ready}, 32'd0);
    d_read = 1'b0;
    @(negedge clk);
    check("bubble_no_accept", {30'd0, ram_re, ram_we}, 32'd0);
    @(negedge clk);
    check("fetch_after_bubble", {31'd0, ram_re}, 32'd1);
    check("fetch_ram_addr", ram_addr, 32'h0000_0020);
    wait_ready(0, seen);
    check("fetch_instr", instruction_out, 32'h0000_0073);
    i_fetch = 1'b0;
    model_drdata = 32'h1111_2222;
    model_instr  = 32'h0000_0073;

    // Randomized accesses against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      int          sel, kind, stalls;
      logic [31:0] addr, wdata, exp;
      sel    = $urandom_range(0, 9);
      kind   = (sel < 3) ? 0 : (sel < 6) ? 1 : (sel < 9) ? 2 : 3;
      addr   = 32'h0000_0400 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      wdata  = $urandom;
      stalls = $urandom_range(0, 3);
      if (addr[1:0] != 2'b00 || kind == 3) model_err = 1'b1;
      if (kind == 0) begin
        model_instr = ref_read(addr);
        exp = model_instr;
      end else if (kind == 1) begin
        model_drdata = ref_read(addr);
        exp = model_drdata;
      end else begin
        exp = model_drdata;
      end
      do_access(kind, addr, wdata, stalls, exp, model_err);
      if (kind >= 2) ref_mem[{addr[31:2], 2'b00}] = wdata;
    end

    // Reset in the first cycle of a fetch aborts it.
    @(negedge clk);
    i_fetch = 1'b1; i_addr = 32'h0000_0010;
    @(negedge clk);
    check("abort_fetch_started", {31'd0, ram_re}, 32'd1);
    rst = 1'b1;
    i_fetch = 1'b0;
    #1;
    check("abort_ram_re", {31'd0, ram_re}, 32'd0);
    check("abort_i_ready", {31'd0, i_ready}, 32'd0);
    check("abort_instr", instruction_out, NOP);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_ready", {31'd0, i_ready}, 32'd0);
    end
    model_err = 1'b0;
    do_access(0, 32'h0000_0010, 32'h0, 0, ref_read(32'h0000_0010), model_err);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
